// File: rtl/fides_ti_pkg.sv
// Shared constants, FSM state type and S-box data for the FIDES threshold
// S-box layer. The share functions are built from the algebraic normal form
// of the S-box, derived here from the lookup table.
package fides_ti_pkg;

  localparam int NSBOX = 32;
  localparam int SW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // S-box lookup table, entry 0 first.
  localparam logic [0:31][4:0] SBOX_TBL = {
    5'd1,  5'd0,  5'd25, 5'd26, 5'd17, 5'd29, 5'd21, 5'd27,
    5'd20, 5'd5,  5'd4,  5'd23, 5'd14, 5'd18, 5'd2,  5'd28,
    5'd15, 5'd8,  5'd6,  5'd3,  5'd13, 5'd7,  5'd24, 5'd16,
    5'd30, 5'd9,  5'd31, 5'd10, 5'd22, 5'd12, 5'd11, 5'd19
  };

  // Moebius transform: entry m is the output-bit coefficient vector of the
  // monomial whose variables are the set bits of m.
  function automatic logic [0:31][4:0] calc_anf();
    logic [0:31][4:0] a;
    a = SBOX_TBL;
    for (int b = 0; b < 5; b++) begin
      for (int x = 0; x < 32; x++) begin
        if (((x >> b) & 1) == 1) begin
          a[5'(x)] = a[5'(x)] ^ a[5'(x - (1 << b))];
        end
      end
    end
    return a;
  endfunction

  localparam logic [0:31][4:0] SBOX_ANF = calc_anf();

  // Lowest share index not used by a term touching shares s and t.
  function automatic int share_owner(input int s, input int t);
    if (s != 0 && t != 0) return 0;
    if (s != 1 && t != 1) return 1;
    return 2;
  endfunction

  // Output share 'own' (0..3) from the three other input shares in
  // ascending index order. The S-box is quadratic, so every expanded term
  // touches at most two shares and is owned by a share it does not touch;
  // share 'own' is therefore never needed.
  function automatic logic [4:0] ti_share(input int own, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] c);
    logic [3:0][4:0] x;
    logic [4:0]      y;
    logic [4:0]      coef;
    int              k;
    k = 0;
    x = '0;
    for (int s = 0; s < 4; s++) begin
      if (s != own) begin
        x[2'(s)] = (k == 0) ? a : ((k == 1) ? b : c);
        k++;
      end
    end
    y = (own == 0) ? SBOX_ANF[0] : 5'd0;
    for (int v = 0; v < 5; v++) begin
      coef = SBOX_ANF[5'(1 << v)];
      for (int s = 0; s < 4; s++) begin
        if (share_owner(s, s) == own) y = y ^ (coef & {5{x[2'(s)][3'(v)]}});
      end
    end
    for (int v = 0; v < 4; v++) begin
      for (int w = v + 1; w < 5; w++) begin
        coef = SBOX_ANF[5'((1 << v) | (1 << w))];
        for (int s = 0; s < 4; s++) begin
          for (int t = 0; t < 4; t++) begin
            if (share_owner(s, t) == own)
              y = y ^ (coef & {5{x[2'(s)][3'(v)] & x[2'(t)][3'(w)]}});
          end
        end
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/fides_ti_sbox.sv
// Four-share threshold S-box slice: input-share register R1, four
// non-complete share functions, output register R2. Optional mask refresh
// on the R2 capture when FIDES_SUB_REFRESH_EN is defined.
module fides_ti_sbox #(
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [SW-1:0] i_x1,
  input  logic [SW-1:0] i_x2,
  input  logic [SW-1:0] i_x3,
  input  logic [SW-1:0] i_x4,
  input  logic [0:14]   i_rnd,
  output logic [SW-1:0] o_y1,
  output logic [SW-1:0] o_y2,
  output logic [SW-1:0] o_y3,
  output logic [SW-1:0] o_y4
);
  import fides_ti_pkg::*;

  logic [SW-1:0] r_r1 [4];
  logic [SW-1:0] r_r2 [4];
  logic [SW-1:0] w_x  [4];
  logic [SW-1:0] w_y  [4];
  logic [SW-1:0] w_m  [4];

  assign w_x[0] = i_x1;
  assign w_x[1] = i_x2;
  assign w_x[2] = i_x3;
  assign w_x[3] = i_x4;

  // Share i never sees input share i.
  assign w_y[0] = ti_share(0, r_r1[1], r_r1[2], r_r1[3]);
  assign w_y[1] = ti_share(1, r_r1[0], r_r1[2], r_r1[3]);
  assign w_y[2] = ti_share(2, r_r1[0], r_r1[1], r_r1[3]);
  assign w_y[3] = ti_share(3, r_r1[0], r_r1[1], r_r1[2]);

`ifdef FIDES_SUB_REFRESH_EN
  // Remask: three fresh masks plus their XOR keep the unshared value intact.
  assign w_m[0] = w_y[0] ^ i_rnd[0:4];
  assign w_m[1] = w_y[1] ^ i_rnd[5:9];
  assign w_m[2] = w_y[2] ^ i_rnd[10:14];
  assign w_m[3] = w_y[3] ^ i_rnd[0:4] ^ i_rnd[5:9] ^ i_rnd[10:14];
`else
  logic w_unused_rnd;
  assign w_unused_rnd = ^i_rnd;
  assign w_m[0] = w_y[0];
  assign w_m[1] = w_y[1];
  assign w_m[2] = w_y[2];
  assign w_m[3] = w_y[3];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_share
    // R1 takes the current slice, R2 the share-function results, while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_r1[g] <= '0;
        r_r2[g] <= '0;
      end else if (i_en) begin
        r_r1[g] <= w_x[g];
        r_r2[g] <= w_m[g];
      end
    end
  end

  assign o_y1 = r_r2[0];
  assign o_y2 = r_r2[1];
  assign o_y3 = r_r2[2];
  assign o_y4 = r_r2[3];

endmodule

// File: rtl/fides_ti_sublayer.sv
// FIDES threshold-implemented S-box layer. One slice per cycle streams from
// the input shift registers through the shared S-box into the output shift
// registers. Handshake: a transfer happens on a rising edge where valid and
// ready are both high; in_ready is high only in IDLE, out_valid only in HOLD,
// and out_s* stay stable while out_valid waits for out_ready.
// Optional feature macro: FIDES_SUB_REFRESH_EN (mask refresh in the S-box).
module fides_ti_sublayer #(
  parameter int NSBOX = 32,
  parameter int SW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:NSBOX*SW-1] in_s1,
  input  logic [0:NSBOX*SW-1] in_s2,
  input  logic [0:NSBOX*SW-1] in_s3,
  input  logic [0:NSBOX*SW-1] in_s4,
  input  logic [0:14]       rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:NSBOX*SW-1] out_s1,
  output logic [0:NSBOX*SW-1] out_s2,
  output logic [0:NSBOX*SW-1] out_s3,
  output logic [0:NSBOX*SW-1] out_s4,
  output logic              busy,
  output logic [1:0]        dbg_state
);
  import fides_ti_pkg::*;

  localparam int W  = NSBOX * SW;
  localparam int CW = $clog2(NSBOX + 2);
  // Slice k leaves R2 on RUN edge k+3; the last one on edge NSBOX+2.
  localparam logic [CW-1:0] C_OUT0 = CW'(2);
  localparam logic [CW-1:0] C_DONE = CW'(NSBOX + 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [0:W-1]  r_in  [4];
  logic [0:W-1]  r_out [4];
  logic [0:W-1]  w_in  [4];
  logic [SW-1:0] w_res [4];
  logic          w_accept;
  logic          w_run;
  logic          w_shift_out;

  assign w_in[0] = in_s1;
  assign w_in[1] = in_s2;
  assign w_in[2] = in_s3;
  assign w_in[3] = in_s4;

  // Next state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (r_cnt == C_DONE) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept    = (r_state == ST_IDLE) && in_valid;
  assign w_run       = (r_state == ST_RUN);
  assign w_shift_out = w_run && (r_cnt >= C_OUT0);
  assign dbg_state   = r_state;

  // State register and RUN cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_run ? r_cnt + CW'(1) : '0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_shreg
    // Input shares load on accept and move one slice toward index 0 per RUN
    // cycle; results enter the output shares at the high-index end.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_in[g]  <= '0;
        r_out[g] <= '0;
      end else begin
        if (w_accept)  r_in[g]  <= w_in[g];
        else if (w_run) r_in[g] <= {r_in[g][SW:W-1], {SW{1'b0}}};
        if (w_shift_out) r_out[g] <= {r_out[g][SW:W-1], w_res[g]};
      end
    end
  end

  fides_ti_sbox #(.SW(SW)) u_sbox (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_run),
    .i_x1  (r_in[0][0:SW-1]),
    .i_x2  (r_in[1][0:SW-1]),
    .i_x3  (r_in[2][0:SW-1]),
    .i_x4  (r_in[3][0:SW-1]),
    .i_rnd (rnd),
    .o_y1  (w_res[0]),
    .o_y2  (w_res[1]),
    .o_y3  (w_res[2]),
    .o_y4  (w_res[3])
  );

  assign out_s1 = r_out[0];
  assign out_s2 = r_out[1];
  assign out_s3 = r_out[2];
  assign out_s4 = r_out[3];

endmodule
